// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one paced UART transmit path
module uart_tx_arbiter #(
   parameter int N_REQ         = 2,
   parameter int BITS_PER_CHAR = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               baud_x1,
   input  logic               tx_ready,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         tx_data,
   output logic               tx_strobe,
   output logic               busy
);
   localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(BITS_PER_CHAR + 1);

   typedef enum logic [1:0] {IDLE, OWN, SEND, LAST} state_t;

   state_t           state, state_n;
   logic [PW-1:0]    owner, owner_n, rr_ptr, rr_ptr_n, pick, idx, nxt;
   logic [CW-1:0]    gap_cnt, gap_n;
   logic [N_REQ-1:0] grant_n, ready_n;
   logic [7:0]       data_n;
   logic             strobe_n, found;

   assign busy = |grant || gap_cnt != '0;
   assign nxt  = owner == PW'(N_REQ - 1) ? '0 : owner + 1'b1;

   // descending scan so the requester closest at/after rr_ptr wins
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr) + k) % N_REQ);
         if (req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_n  = state;
      owner_n  = owner;
      rr_ptr_n = rr_ptr;
      grant_n  = grant;
      ready_n  = '0;
      strobe_n = 1'b0;
      data_n   = tx_data;
      gap_n    = baud_x1 && gap_cnt != '0 && !tx_strobe ? gap_cnt - 1'b1 : gap_cnt;
      case (state)
         IDLE: if (found) begin
            owner_n = pick;
            grant_n = N_REQ'(1) << pick;
            state_n = OWN;
         end
         OWN: if (!req_valid[owner]) begin
            grant_n  = '0;
            rr_ptr_n = nxt;
            state_n  = IDLE;
         end else if (gap_cnt == '0 && tx_ready) begin
            strobe_n = 1'b1;
            data_n   = req_data[{owner, 3'b000} +: 8];
            ready_n  = N_REQ'(1) << owner;
            gap_n    = CW'(BITS_PER_CHAR);
            state_n  = req_last[owner] ? LAST : SEND;
         end
         SEND: state_n = OWN;
         LAST: begin
            grant_n  = '0;
            rr_ptr_n = nxt;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         gap_cnt   <= '0;
         grant     <= '0;
         req_ready <= '0;
         tx_data   <= 8'h00;
         tx_strobe <= 1'b0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         rr_ptr    <= rr_ptr_n;
         gap_cnt   <= gap_n;
         grant     <= grant_n;
         req_ready <= ready_n;
         tx_data   <= data_n;
         tx_strobe <= strobe_n;
      end
   end
endmodule
